instr_fetch: RTL and testbench

Instruction-fetch stage of the RISC-V core; it sits directly upstream of the synchronous instruction ROM. It owns the program counter, drives the ROM byte address, and re-aligns the ROM's one-cycle-late instruction with its PC. It presents a valid-tagged {PC, instruction} pair to decode and handles stall and branch/jump redirect.

---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_pc_reg.sv | 37 +++
 rtl/instr_fetch.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared core constants for the fetch stage (and for decode, which reuses the
// NOP encoding when it squashes a slot).
//   DEFAULT_RESET_PC  : PC loaded when the core comes out of reset
//   DEFAULT_NOP_INSTR : addi x0,x0,0, shown on the IF outputs for bubbles
//   INSTR_W           : instruction / address width
//   fetch_state_e     : RUN, HOLD (stall capture), HALT (misalign trap)
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

   localparam int          INSTR_W           = 32;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program-counter register of the fetch stage: reset-load, redirect load and
// the sequential +4 step. The counter wraps modulo 2^32.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   advance    : step the PC by one instruction
//   load       : redirect, takes priority over advance
//   load_addr  : redirect byte address
//   pc         : current fetch address
// ---------------------------------------------------------------------------
module pc_reg
   import instr_fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               advance,
   input  logic               load,
   input  logic [INSTR_W-1:0] load_addr,
   output logic [INSTR_W-1:0] pc
);

   // Redirect beats the sequential step; with neither, the PC simply holds
   // (stall, or a halted stage).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_addr;
      end else if (advance) begin
         pc <= pc + 32'd4;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage sitting in front of a synchronous instruction ROM.
// It owns the PC, drives the ROM address, and pairs the ROM's one-cycle-late
// data with the PC that requested it. Stall freezes the stage and captures
// the current word; a branch redirect wins over stall and costs one bubble.
//
// Optional feature (macro INSTR_FETCH_MISALIGN_EN): a redirect to a target
// whose low two bits are non-zero raises a sticky IF_EXC and halts the stage
// until reset. Without the macro the target is silently word-aligned and
// IF_EXC is constant 0.
//
// Ports:
//   CLK, RESET     : clock, asynchronous active-high reset
//   STALL          : decode cannot accept, hold the IF outputs
//   BRANCH_TAKEN   : redirect request from execute
//   BRANCH_TARGET  : redirect byte address
//   INS_ADDRESS    : byte address to the ROM (ROM uses [31:2])
//   INSTRUCTION    : ROM data for the address of the previous edge
//   IF_PC/IF_INSTR : PC and instruction presented to decode
//   IF_VALID       : the IF pair is a real instruction
//   IF_EXC         : misaligned redirect target exception
// ---------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               STALL,
   input  logic               BRANCH_TAKEN,
   input  logic [INSTR_W-1:0] BRANCH_TARGET,
   output logic [INSTR_W-1:0] INS_ADDRESS,
   input  logic [INSTR_W-1:0] INSTRUCTION,
   output logic [INSTR_W-1:0] IF_PC,
   output logic [INSTR_W-1:0] IF_INSTR,
   output logic               IF_VALID,
   output logic               IF_EXC
);

   fetch_state_e       state_q, state_d;
   logic [INSTR_W-1:0] pc_q;
   logic [INSTR_W-1:0] req_pc, req_pc_d;
   logic               req_valid, req_valid_d;
   logic [INSTR_W-1:0] hold_instr, hold_instr_d;
   logic               hold_q;
   logic               halted;
   logic               pc_load, pc_advance;
   logic [INSTR_W-1:0] target_aligned;

`ifdef INSTR_FETCH_MISALIGN_EN
   logic exc_q, exc_d;
   logic misaligned;
   assign misaligned = |BRANCH_TARGET[1:0];
   assign halted     = (state_q == ST_HALT);
`else
   assign halted     = 1'b0;
`endif

   assign target_aligned = {BRANCH_TARGET[INSTR_W-1:2], 2'b00};
   assign hold_q         = (state_q == ST_HOLD);

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk       (CLK),
      .rst       (RESET),
      .advance   (pc_advance),
      .load      (pc_load),
      .load_addr (target_aligned),
      .pc        (pc_q)
   );

   // Next-state logic in priority order: halt freezes everything, redirect
   // beats stall, stall only captures the word on entry to HOLD (later
   // stalled edges see the ROM answering pc_q, not req_pc), and otherwise
   // the stage advances by one instruction.
   always_comb begin
      state_d      = state_q;
      req_pc_d     = req_pc;
      req_valid_d  = req_valid;
      hold_instr_d = hold_instr;
      pc_load      = 1'b0;
      pc_advance   = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_EN
      exc_d        = exc_q;
`endif
      if (halted) begin
         state_d = state_q;
      end else if (BRANCH_TAKEN) begin
         req_valid_d = 1'b0;
         state_d     = ST_RUN;
         pc_load     = 1'b1;
`ifdef INSTR_FETCH_MISALIGN_EN
         if (misaligned) begin
            pc_load = 1'b0;
            state_d = ST_HALT;
            exc_d   = 1'b1;
         end
`endif
      end else if (STALL) begin
         if (state_q == ST_RUN) begin
            hold_instr_d = INSTRUCTION;
            state_d      = ST_HOLD;
         end
      end else begin
         req_pc_d    = pc_q;
         req_valid_d = 1'b1;
         pc_advance  = 1'b1;
         state_d     = ST_RUN;
      end
   end

   // Stage registers; reset drops any hold, halt or pending redirect at once.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_RUN;
         req_pc     <= '0;
         req_valid  <= 1'b0;
         hold_instr <= '0;
      end else begin
         state_q    <= state_d;
         req_pc     <= req_pc_d;
         req_valid  <= req_valid_d;
         hold_instr <= hold_instr_d;
      end
   end

`ifdef INSTR_FETCH_MISALIGN_EN
   // Sticky exception flag, only cleared by reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         exc_q <= 1'b0;
      end else begin
         exc_q <= exc_d;
      end
   end
   assign IF_EXC = exc_q;
`else
   assign IF_EXC = 1'b0;
`endif

   // Output mux: a captured word outranks the live ROM data, bubbles show NOP.
   always_comb begin
      if (hold_q) begin
         IF_INSTR = hold_instr;
      end else if (req_valid) begin
         IF_INSTR = INSTRUCTION;
      end else begin
         IF_INSTR = NOP_INSTR;
      end
   end

   assign INS_ADDRESS = pc_q;
   assign IF_PC       = req_pc;
   assign IF_VALID    = req_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Bench for instr_fetch: a behavioural ROM, directed scenarios (reset,
// Fibonacci run, stall, redirect vs stall, misaligned target, PC wrap via a
// second instance) and a randomized stall/branch phase, all checked against
// a reference model of the stage kept here.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] ins_address;
   logic [31:0] instruction;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        if_exc;

   logic [31:0] w_ins_address;
   logic [31:0] w_instruction;
   logic [31:0] w_if_pc;
   logic [31:0] w_if_instr;
   logic        w_if_valid;
   logic        w_if_exc;

   logic [31:0] rom_mem [0:63];

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: the fetch pointer, the pair currently presented, and
   // whether the stage is frozen by a stall or by a misalign trap.
   logic [31:0] m_pc;
   logic [31:0] m_rpc;
   logic        m_valid;
   logic        m_hold;
   logic        m_halt;
   logic        m_exc;

   always #5 CLK = ~CLK;

   instr_fetch dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .STALL         (stall),
      .BRANCH_TAKEN  (branch_taken),
      .BRANCH_TARGET (branch_target),
      .INS_ADDRESS   (ins_address),
      .INSTRUCTION   (instruction),
      .IF_PC         (if_pc),
      .IF_INSTR      (if_instr),
      .IF_VALID      (if_valid),
      .IF_EXC        (if_exc)
   );

   instr_fetch #(
      .RESET_PC (WRAP_PC)
   ) dut_wrap (
      .CLK           (CLK),
      .RESET         (RESET),
      .STALL         (1'b0),
      .BRANCH_TAKEN  (1'b0),
      .BRANCH_TARGET (32'h0),
      .INS_ADDRESS   (w_ins_address),
      .INSTRUCTION   (w_instruction),
      .IF_PC         (w_if_pc),
      .IF_INSTR      (w_if_instr),
      .IF_VALID      (w_if_valid),
      .IF_EXC        (w_if_exc)
   );

   // ROM contents: a small table for low addresses, a hash elsewhere.
   function automatic logic [31:0] romWord(input logic [31:0] addr);
      if (addr < 32'd256) begin
         return rom_mem[addr[7:2]];
      end
      return {addr[31:2], 2'b00} ^ 32'h1357_9BDF;
   endfunction

   // Synchronous ROMs answering the address sampled at each edge.
   always @(posedge CLK) begin
      instruction   <= romWord(ins_address);
      w_instruction <= romWord(w_ins_address);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      m_pc    = 32'h0;
      m_rpc   = 32'h0;
      m_valid = 1'b0;
      m_hold  = 1'b0;
      m_halt  = 1'b0;
      m_exc   = 1'b0;
   endtask

   // One clock edge of the stage as described behaviourally.
   task automatic modelStep(input logic s, input logic b, input logic [31:0] t);
      if (m_halt) begin
         return;
      end
      if (b) begin
`ifdef INSTR_FETCH_MISALIGN_EN
         if (t[1:0] != 2'b00) begin
            m_halt  = 1'b1;
            m_exc   = 1'b1;
            m_valid = 1'b0;
            m_hold  = 1'b0;
            return;
         end
`endif
         m_pc    = t & 32'hFFFF_FFFC;
         m_valid = 1'b0;
         m_hold  = 1'b0;
      end else if (s) begin
         m_hold = 1'b1;
      end else begin
         m_rpc   = m_pc;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
         m_hold  = 1'b0;
      end
   endtask

   // A valid pair must always carry the ROM word at its own PC; a bubble that
   // is not frozen shows NOP.
   task automatic checkAll();
      checkOutput("ins_address", ins_address, m_pc);
      checkOutput("if_pc", if_pc, m_rpc);
      checkOutput("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      checkOutput("if_exc", {31'b0, if_exc}, {31'b0, m_exc});
      if (m_valid) begin
         checkOutput("if_instr", if_instr, romWord(m_rpc));
      end else if (!m_hold) begin
         checkOutput("if_instr_nop", if_instr, NOP);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t);
      stall         = s;
      branch_taken  = b;
      branch_target = t;
      @(posedge CLK);
      modelStep(s, b, t);
      #1;
      checkAll();
   endtask

   // Asynchronous reset, checked before any clock edge, released on a
   // falling edge so the next rising edge is the first fetch.
   task automatic doReset();
      stall        = 1'b0;
      branch_taken = 1'b0;
      RESET        = 1'b1;
      #2;
      modelReset();
      checkAll();
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin
      logic [31:0] tgt;
      logic        s, b;

      rom_mem[0] = 32'h0050_0093;
      rom_mem[1] = 32'h0000_0113;
      rom_mem[2] = 32'h0010_0193;
      rom_mem[3] = 32'h0031_0233;
      rom_mem[4] = 32'h0001_8113;
      rom_mem[5] = 32'h0002_0193;
      rom_mem[6] = 32'hFFF0_8093;
      rom_mem[7] = 32'hFE00_98E3;
      for (int i = 8; i < 64; i++) begin
         rom_mem[i] = 32'hC000_0000 | (i * 32'h0101_0007);
      end

      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      RESET         = 1'b1;
      #3;
      doReset();
      checkOutput("wrap_reset_addr", w_ins_address, WRAP_PC);
      checkOutput("wrap_reset_valid", {31'b0, w_if_valid}, 32'h0);

      // Free-running Fibonacci image; first edge also checks the wrap instance.
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("first_instr", if_instr, 32'h0050_0093);
      checkOutput("first_addr", ins_address, 32'h4);
      checkOutput("wrap_pc0", w_if_pc, WRAP_PC);
      checkOutput("wrap_valid0", {31'b0, w_if_valid}, 32'h1);
      checkOutput("wrap_instr0", w_if_instr, romWord(WRAP_PC));
      checkOutput("wrap_addr0", w_ins_address, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("wrap_pc1", w_if_pc, 32'h0);
      checkOutput("wrap_instr1", w_if_instr, 32'h0050_0093);
      for (int i = 2; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
      end
      checkOutput("fib_last_pc", if_pc, 32'd28);

      // Stall three cycles at IF_PC=8, then release to 12.
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         checkOutput("stall_pc", if_pc, 32'd8);
         checkOutput("stall_instr", if_instr, 32'h0010_0193);
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("release_pc", if_pc, 32'd12);
      checkOutput("release_instr", if_instr, 32'h0031_0233);

      // Redirect together with stall: redirect wins, one bubble.
      applyStimulus(1'b1, 1'b1, 32'h40);
      checkOutput("redir_bubble", {31'b0, if_valid}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("redir_pc", if_pc, 32'h40);
      checkOutput("redir_instr", if_instr, rom_mem[16]);

      // Misaligned redirect target.
      applyStimulus(1'b0, 1'b1, 32'h42);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef INSTR_FETCH_MISALIGN_EN
      checkOutput("misalign_exc", {31'b0, if_exc}, 32'h1);
      checkOutput("misalign_valid", {31'b0, if_valid}, 32'h0);
`else
      checkOutput("misalign_pc", if_pc, 32'h44);
      checkOutput("misalign_exc", {31'b0, if_exc}, 32'h0);
`endif

      // Reset in the middle of a stall clears the hold immediately.
      doReset();
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      doReset();

      // Randomized stall / redirect traffic.
      for (int i = 0; i < 300; i++) begin
         s   = ($urandom_range(0, 99) < 30);
         b   = ($urandom_range(0, 9) == 0);
         tgt = $urandom_range(0, 63) * 4;
`ifndef INSTR_FETCH_MISALIGN_EN
         if ($urandom_range(0, 3) == 0) begin
            tgt = tgt | 32'h2;
         end
`endif
         applyStimulus(s, b, tgt);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
